// File: rtl/sram_responder.sv
// Purpose: on-chip ZBT SRAM stand-in with late write commit and read forwarding; optional macro SRAM_STATS_EN adds access counters.
// Latency: every read returns exactly LATENCY cycles after issue; writes commit LATENCY cycles after issue.
// Backpressure: none; one request is accepted every cycle outside reset.
module sram_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH_W = 10,
    parameter int ADDR_W  = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] memory_address,
    input  logic [31:0]       memory_write,
    input  logic              memory_write_enable,
    output logic [31:0]       memory_read,
    output logic              read_valid
`ifdef SRAM_STATS_EN
    ,
    output logic [31:0]       access_reads,
    output logic [31:0]       access_writes
`endif
);

    localparam int DEPTH = 1 << DEPTH_W;
    localparam int LAST  = LATENCY - 1;

    // Word storage; never reset, contents survive a reset.
    logic [31:0] mem [DEPTH];
    logic [31:0] ram_q;

    // Pipeline stage fields. Index 0 is S1, index LAST is SL.
    // s_dat carries write data for writes and (possibly corrected) read data for reads.
    logic [LATENCY-1:0] s_vld;
    logic [LATENCY-1:0] s_we;
    logic [DEPTH_W-1:0] s_idx [LATENCY];
    logic [31:0]        s_dat [LATENCY];
    // S1 read data was already overridden by a write committing on its issue edge.
    logic               s0_fix;
    logic [31:0]        cur_dat [LATENCY];

    logic [DEPTH_W-1:0] req_idx;
    logic               commit_vld;
    logic [DEPTH_W-1:0] commit_idx;
    logic [31:0]        commit_dat;
    logic               unused_addr_hi;

    // Upper address bits alias onto the same word.
    assign req_idx        = memory_address[DEPTH_W-1:0];
    assign unused_addr_hi = ^memory_address[ADDR_W-1:DEPTH_W];

    // A write leaving SL commits, unless reset discards it.
    assign commit_vld = s_vld[LAST] & s_we[LAST] & ~reset;
    assign commit_idx = s_idx[LAST];
    assign commit_dat = cur_dat[LAST];

    // Effective data per stage; S1 reads take the RAM output unless patched at issue.
    always_comb begin
        for (int k = 0; k < LATENCY; k++) begin
            cur_dat[k] = s_dat[k];
        end
        if (!s_we[0] && !s0_fix) begin
            cur_dat[0] = ram_q;
        end
    end

    // Block RAM: late write from SL, read-first synchronous read at issue.
    always_ff @(posedge clk) begin
        if (commit_vld) begin
            mem[commit_idx] <= commit_dat;
        end
        ram_q <= mem[req_idx];
    end

    // Advance the request pipeline. Every committing write is older than every
    // read still in flight (including the one issuing now), and commits arrive in
    // issue order, so patching matching reads on each commit leaves them holding
    // the youngest older write by the time they reach the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_vld <= '0;
        end else begin
            s_vld[0] <= 1'b1;
            for (int k = 1; k < LATENCY; k++) begin
                s_vld[k] <= s_vld[k-1];
            end
        end

        s_we[0]  <= memory_write_enable;
        s_idx[0] <= req_idx;
        s0_fix   <= !memory_write_enable && commit_vld && (commit_idx == req_idx);
        s_dat[0] <= memory_write_enable ? memory_write : commit_dat;

        for (int k = 1; k < LATENCY; k++) begin
            s_we[k]  <= s_we[k-1];
            s_idx[k] <= s_idx[k-1];
            if (!s_we[k-1] && commit_vld && (commit_idx == s_idx[k-1])) begin
                s_dat[k] <= commit_dat;
            end else begin
                s_dat[k] <= cur_dat[k-1];
            end
        end
    end

    // Registered output: update on reads leaving SL, hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            memory_read <= 32'd0;
            read_valid  <= 1'b0;
        end else if (s_vld[LAST] && !s_we[LAST]) begin
            memory_read <= cur_dat[LAST];
            read_valid  <= 1'b1;
        end else begin
            read_valid  <= 1'b0;
        end
    end

`ifdef SRAM_STATS_EN
    // Count accepted requests by kind; free-running wrap at 2**32.
    always_ff @(posedge clk) begin
        if (reset) begin
            access_reads  <= 32'd0;
            access_writes <= 32'd0;
        end else if (memory_write_enable) begin
            access_writes <= access_writes + 32'd1;
        end else begin
            access_reads  <= access_reads + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Purpose: self-checking bench for sram_responder against a behavioural memory model.
// Latency: model delays each read result by LAT cycles from its issue edge.
// Backpressure: none; a request is driven every cycle.
module tb_sram_responder;

    localparam int LAT = 2;
    localparam int DW  = 10;
    localparam int AW  = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [31:0]   wdat = '0;
    logic          we = 1'b0;
    logic [31:0]   memory_read;
    logic          read_valid;
`ifdef SRAM_STATS_EN
    logic [31:0]   access_reads;
    logic [31:0]   access_writes;
`endif

    sram_responder #(.LATENCY(LAT), .DEPTH_W(DW), .ADDR_W(AW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .memory_address      (addr),
        .memory_write        (wdat),
        .memory_write_enable (we),
        .memory_read         (memory_read),
        .read_valid          (read_valid)
`ifdef SRAM_STATS_EN
        ,
        .access_reads        (access_reads),
        .access_writes       (access_writes)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: memory updated at issue time (a read sees every write
    // issued before it); results emerge LAT cycles later. Uncommitted writes are
    // undone on reset.
    typedef struct {
        bit            rd;
        bit            wr;
        bit            known;
        logic [31:0]   d;
        logic [DW-1:0] idx;
        logic [31:0]   prev;
        bit            prev_known;
    } ent_t;

    ent_t        dq[$];
    logic [31:0] mmem   [1<<DW];
    bit          mknown [1<<DW];
    bit          m_rv = 1'b0;
    logic [31:0] m_rd = '0;
    bit          m_known = 1'b1;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin : model
        ent_t e;
        if (reset) begin
            while (dq.size() > 0) begin
                e = dq.pop_back();
                if (e.wr) begin
                    mmem[e.idx]   = e.prev;
                    mknown[e.idx] = e.prev_known;
                end
            end
            m_rv    = 1'b0;
            m_rd    = 32'd0;
            m_known = 1'b1;
        end else begin
            e.idx        = addr[DW-1:0];
            e.wr         = we;
            e.rd         = !we;
            e.known      = mknown[e.idx];
            e.d          = mmem[e.idx];
            e.prev       = mmem[e.idx];
            e.prev_known = mknown[e.idx];
            if (we) begin
                mmem[e.idx]   = wdat;
                mknown[e.idx] = 1'b1;
            end
            dq.push_back(e);
            m_rv = 1'b0;
            if (dq.size() > LAT) begin
                e = dq.pop_front();
                if (e.rd) begin
                    m_rv    = 1'b1;
                    m_rd    = e.d;
                    m_known = e.known;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("read_valid", {31'd0, read_valid}, {31'd0, m_rv});
            if (m_known) begin
                chk("memory_read", memory_read, m_rd);
            end
        end
    end

    task automatic step(input bit w, input logic [AW-1:0] a, input logic [31:0] d);
        we   = w;
        addr = a;
        wdat = d;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, '0, 32'd0);
    endtask

    initial begin
        logic [AW-1:0] ra;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_memory_read", memory_read, 32'd0);
        chk("reset_read_valid", {31'd0, read_valid}, 32'd0);
`ifdef SRAM_STATS_EN
        chk("reset_reads", access_reads, 32'd0);
        chk("reset_writes", access_writes, 32'd0);
`endif
        chk_en = 1'b1;
        reset  = 1'b0;
        step(1'b1, 20'd0, 32'd0);

        // 1: forwarded write->read turnaround of one cycle
        step(1'b1, 20'd15, 32'd10);
        step(1'b0, 20'd15, 32'd0);
        idle(); idle();
        chk("t1_fwd_data", memory_read, 32'd10);
        chk("t1_valid", {31'd0, read_valid}, 32'd1);

        // 2: back-to-back writes then reads on consecutive cycles
        step(1'b1, 20'd20, 32'd9);
        step(1'b1, 20'd21, 32'd10);
        step(1'b0, 20'd20, 32'd0);
        step(1'b0, 20'd21, 32'd0);
        idle();
        chk("t2_read20", memory_read, 32'd9);
        idle();
        chk("t2_read21", memory_read, 32'd10);

        // 3: same-index writes, last wins, and address aliasing
        step(1'b1, 20'd7, 32'd5);
        step(1'b1, 20'd7, 32'd6);
        step(1'b0, 20'd7, 32'd0);
        idle(); idle();
        chk("t3_last_wins", memory_read, 32'd6);
        step(1'b0, 20'd1031, 32'd0);
        idle(); idle();
        chk("t3_alias", memory_read, 32'd6);

        // 4: committed write read back from the array after idle reads
        step(1'b1, 20'd3, 32'd30);
        repeat (4) idle();
        chk("t4_idle_valid", {31'd0, read_valid}, 32'd1);
        step(1'b0, 20'd3, 32'd0);
        idle(); idle();
        chk("t4_array", memory_read, 32'd30);

        // 5: reset discards an in-flight write
        step(1'b1, 20'd40, 32'd111);
        idle(); idle();
        step(1'b1, 20'd40, 32'd77);
        reset = 1'b1;
        idle();
        chk("t5_rst_data", memory_read, 32'd0);
        chk("t5_rst_valid", {31'd0, read_valid}, 32'd0);
        reset = 1'b0;
        step(1'b0, 20'd40, 32'd0);
        idle(); idle();
        chk("t5_old_value", memory_read, 32'd111);

`ifdef SRAM_STATS_EN
        // 6: access counters
        reset = 1'b1;
        idle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 20'(100 + i), 32'(i));
        repeat (5) idle();
        chk("t6_writes", access_writes, 32'd3);
        chk("t6_reads", access_reads, 32'd5);
        reset = 1'b1;
        idle();
        chk("t6_writes_rst", access_writes, 32'd0);
        chk("t6_reads_rst", access_reads, 32'd0);
        reset = 1'b0;
`endif

        // Randomized traffic over a small aliased address window with rare resets
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            ra = '0;
            ra[3:0] = 4'($urandom);
            ra[DW+1:DW] = 2'($urandom);
            step(1'($urandom_range(0, 1)), ra, $urandom);
        end
        reset = 1'b0;
        repeat (LAT + 2) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
